// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port data_memory arbiter/sequencer; define DMEM_ARB_FIXED_PRIO_EN for fixed port-0 priority
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic              err0,
    output logic              err1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_memread,
    output logic              mem_memwrite,
    input  logic [DATA_W-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // One extra bit so MEM_WORDS itself is representable when ADDR_W is small
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W+1)'(MEM_WORDS);

    state_t            state;
    logic              sel;        // port that owns the current transaction
    logic              cur_we;
    logic              cur_oor;

    logic              grant_any;
    logic              grant_port;
    logic              sel_we;
    logic              sel_oor;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

`ifndef DMEM_ARB_FIXED_PRIO_EN
    logic              last_served;
`endif

    // Pick the winning port and mux its request fields
    always_comb begin
        grant_any = req0 | req1;
        if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            grant_port = 1'b0;
`else
            grant_port = ~last_served;
`endif
        end else begin
            grant_port = req1;
        end
        sel_we    = grant_port ? we1    : we0;
        sel_addr  = grant_port ? addr1  : addr0;
        sel_wdata = grant_port ? wdata1 : wdata0;
        sel_oor   = ({1'b0, sel_addr} >= ADDR_LIMIT);
    end

    // Transaction sequencer: IDLE -> ACCESS (strobes) -> RESP (done) -> IDLE
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            sel            <= 1'b0;
            cur_we         <= 1'b0;
            cur_oor        <= 1'b0;
            gnt0           <= 1'b0;
            gnt1           <= 1'b0;
            done0          <= 1'b0;
            done1          <= 1'b0;
            err0           <= 1'b0;
            err1           <= 1'b0;
            busy           <= 1'b0;
            rdata          <= '0;
            mem_address    <= '0;
            mem_write_data <= '0;
            mem_memread    <= 1'b0;
            mem_memwrite   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
            last_served    <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    rdata <= '0;
                    if (grant_any) begin
                        state          <= ACCESS;
                        sel            <= grant_port;
                        gnt0           <= ~grant_port;
                        gnt1           <= grant_port;
                        busy           <= 1'b1;
                        mem_address    <= sel_addr;
                        mem_write_data <= sel_wdata;
                        cur_we         <= sel_we;
                        cur_oor        <= sel_oor;
                        // Out-of-range accesses keep both strobes low
                        mem_memread    <= ~sel_we & ~sel_oor;
                        mem_memwrite   <= sel_we & ~sel_oor;
`ifndef DMEM_ARB_FIXED_PRIO_EN
                        last_served    <= grant_port;
`endif
                    end
                end
                ACCESS: begin
                    state        <= RESP;
                    mem_memread  <= 1'b0;
                    mem_memwrite <= 1'b0;
                    done0        <= ~sel;
                    done1        <= sel;
                    err0         <= ~sel & cur_oor;
                    err1         <= sel & cur_oor;
                    rdata        <= (!cur_we && !cur_oor) ? mem_read_data : '0;
                end
                RESP: begin
                    state <= IDLE;
                    gnt0  <= 1'b0;
                    gnt1  <= 1'b0;
                    busy  <= 1'b0;
                    done0 <= 1'b0;
                    done1 <= 1'b0;
                    err0  <= 1'b0;
                    err1  <= 1'b0;
                    rdata <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic        gnt0, gnt1, done0, done1, err0, err1, busy;
    logic [31:0] rdata, mem_address, mem_write_data, mem_read_data;
    logic        mem_memread, mem_memwrite;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(256)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .err0(err0), .err1(err1), .rdata(rdata), .busy(busy),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .mem_read_data(mem_read_data)
    );

    // data_memory stand-in: combinational read, write on the edge ending a write strobe
    logic [31:0] mem [0:255];
    assign mem_read_data = (mem_address < 32'd256) ? mem[mem_address[7:0]] : 32'hDEADBEEF;
    always @(posedge clk)
        if (mem_memwrite && !reset && mem_address < 32'd256)
            mem[mem_address[7:0]] <= mem_write_data;

    int n_checks = 0;
    int n_fail = 0;
    bit check_en = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level reference: owner of the memory and cycles elapsed since its grant
    int          owner = -1;
    int          age = 0;
    int          w;
    bit          last = 1'b1;
    logic        t_we = 1'b0, t_oor = 1'b0;
    logic [31:0] t_addr = '0, t_wdata = '0, result = '0;
    logic [31:0] e_addr = '0, e_wdata = '0;
    logic [31:0] ref_mem [0:255];

    always @(posedge clk) begin
        if (reset) begin
            owner   = -1;
            last    = 1'b1;
            e_addr  = '0;
            e_wdata = '0;
        end else if (owner < 0) begin
            w = -1;
            if (req0 && req1) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
                w = 0;
`else
                w = last ? 0 : 1;
`endif
            end else if (req0) w = 0;
            else if (req1) w = 1;
            if (w >= 0) begin
                owner   = w;
                age     = 0;
                last    = (w == 1);
                t_we    = (w == 1) ? we1 : we0;
                t_addr  = (w == 1) ? addr1 : addr0;
                t_wdata = (w == 1) ? wdata1 : wdata0;
                t_oor   = (t_addr >= 32'd256);
                e_addr  = t_addr;
                e_wdata = t_wdata;
            end
        end else if (age == 0) begin
            age = 1;
            result = '0;
            if (!t_oor) begin
                if (t_we) ref_mem[t_addr[7:0]] = t_wdata;
                else result = ref_mem[t_addr[7:0]];
            end
        end else begin
            owner = -1;
        end
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        if (check_en) begin
            chk("gnt0", gnt0, owner == 0);
            chk("gnt1", gnt1, owner == 1);
            chk("busy", busy, owner >= 0);
            chk("memread", mem_memread, owner >= 0 && age == 0 && !t_oor && !t_we);
            chk("memwrite", mem_memwrite, owner >= 0 && age == 0 && !t_oor && t_we);
            chk("done0", done0, owner == 0 && age == 1);
            chk("done1", done1, owner == 1 && age == 1);
            chk("err0", err0, owner == 0 && age == 1 && t_oor);
            chk("err1", err1, owner == 1 && age == 1 && t_oor);
            chk("rdata", rdata, (owner >= 0 && age == 1) ? result : 32'h0);
            chk("mem_address", mem_address, e_addr);
            chk("mem_write_data", mem_write_data, e_wdata);
            chk("strobe_excl", mem_memread & mem_memwrite, 0);
        end
    end

    // Grant order log, one entry per rising gnt
    int   glog[$];
    logic pg0 = 1'b0, pg1 = 1'b0;
    always @(negedge clk) begin
        if (gnt0 && !pg0) glog.push_back(0);
        if (gnt1 && !pg1) glog.push_back(1);
        pg0 = gnt0;
        pg1 = gnt1;
    end

    task automatic do_access(input int port, input logic we, input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] rd, output logic er, output int lat);
        @(negedge clk);
        if (port == 0) begin req0 = 1; we0 = we; addr0 = a; wdata0 = d; end
        else begin req1 = 1; we1 = we; addr1 = a; wdata1 = d; end
        lat = 0; rd = '0; er = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if ((port == 0) ? done0 : done1) begin
                lat = i;
                rd  = rdata;
                er  = (port == 0) ? err0 : err1;
                break;
            end
        end
        if (port == 0) req0 = 0; else req1 = 0;
        repeat (2) @(negedge clk);
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 19);
        if (r == 0) return 32'd256 + 32'($urandom_range(0, 3));
        if (r == 1) return $urandom;
        return 32'($urandom_range(0, 15));
    endfunction

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          extra;
    int          exp_ord[4];

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'(i);
            ref_mem[i] = 32'(i);
        end
`ifdef DMEM_ARB_FIXED_PRIO_EN
        exp_ord = '{0, 0, 0, 0};
`else
        exp_ord = '{0, 1, 0, 1};
`endif
        repeat (3) @(negedge clk);
        reset = 0;
        check_en = 1;
        chk("rst_gnt", {gnt0, gnt1}, 0);
        chk("rst_done_err", {done0, done1, err0, err1}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_strobes", {mem_memread, mem_memwrite}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_addr_wdata", {mem_address, mem_write_data}, 0);

        // Contention: both held high for four grants
        glog.delete();
        req0 = 1; we0 = 0; addr0 = 10;
        req1 = 1; we1 = 0; addr1 = 11;
        for (int i = 0; i < 40 && glog.size() < 4; i++) begin
            @(negedge clk);
            #1;
        end
        req0 = 0; req1 = 0;
        chk("cont_count", glog.size(), 4);
        for (int k = 0; k < 4; k++)
            if (k < glog.size()) chk($sformatf("cont_order%0d", k), glog[k], exp_ord[k]);
        repeat (4) @(negedge clk);

        // Single read
        do_access(0, 1'b0, 32'd4, 32'h0, rd, er, lat);
        chk("rd4_data", rd, 32'h4);
        chk("rd4_err", er, 0);
        chk("rd4_latency", lat, 2);

        // Write then read through port 1
        do_access(1, 1'b1, 32'd4, 32'hFFFFFFFB, rd, er, lat);
        chk("wr4_latency", lat, 2);
        chk("wr4_rdata", rd, 0);
        do_access(1, 1'b0, 32'd4, 32'h0, rd, er, lat);
        chk("rdback4_data", rd, 32'hFFFFFFFB);

        // Out of range
        do_access(0, 1'b0, 32'd256, 32'h0, rd, er, lat);
        chk("oor_err", er, 1);
        chk("oor_rdata", rd, 0);
        chk("oor_latency", lat, 2);

        // Reset during ACCESS of a write
        @(negedge clk);
        req0 = 1; we0 = 1; addr0 = 8; wdata0 = 32'h12345678;
        @(negedge clk);
        chk("rstmid_in_access", {gnt0, mem_memwrite}, 2'b11);
        reset = 1; req0 = 0;
        @(negedge clk);
        chk("rstmid_strobes", {mem_memread, mem_memwrite}, 0);
        chk("rstmid_done", {done0, err0, gnt0, busy}, 0);
        chk("rstmid_regs", {rdata, mem_address, mem_write_data}, 0);
        reset = 0;
        do_access(0, 1'b0, 32'd8, 32'h0, rd, er, lat);
        chk("rstmid_rd8", rd, 32'h8);

        // Request dropped during ACCESS
        @(negedge clk);
        req0 = 1; we0 = 0; addr0 = 5;
        @(negedge clk);
        chk("drop_gnt", gnt0, 1);
        req0 = 0;
        @(negedge clk);
        chk("drop_done", done0, 1);
        chk("drop_rdata", rdata, 32'h5);
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (done0 || gnt0) extra++;
        end
        chk("drop_no_regrant", extra, 0);

        // Randomized traffic
        repeat (3000) begin
            @(negedge clk);
            if ($urandom_range(0, 299) == 0) begin
                reset = 1; req0 = 0; req1 = 0;
            end else begin
                reset = 0;
                if (req0 && done0) req0 = 0;
                else if (req0 && gnt0 && $urandom_range(0, 7) == 0) req0 = 0;
                else if (!req0 && !gnt0 && $urandom_range(0, 2) == 0) begin
                    req0 = 1; we0 = 1'($urandom_range(0, 1)); addr0 = rand_addr(); wdata0 = $urandom;
                end
                if (req1 && done1) req1 = 0;
                else if (req1 && gnt1 && $urandom_range(0, 7) == 0) req1 = 0;
                else if (!req1 && !gnt1 && $urandom_range(0, 2) == 0) begin
                    req1 = 1; we1 = 1'($urandom_range(0, 1)); addr1 = rand_addr(); wdata1 = $urandom;
                end
            end
        end
        @(negedge clk);
        reset = 0; req0 = 0; req1 = 0;
        repeat (6) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
